// File: rtl/decoder_seq_out.sv
// One-hot output decoder with a direct-select mode and a timed sweep mode
// that walks bit 0 up to a chosen end index, holding each output dwell+1 cycles.
module decoder_seq_out #(
  parameter int IN_SIZE  = 6,
  parameter int OUT_SIZE = 34,
  parameter int DWELL_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_SIZE-1:0]  in,
  input  logic                mode,
  input  logic                in_valid,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic                clr,
  output logic                in_ready,
  output logic [OUT_SIZE-1:0] out,
  output logic                busy,
  output logic                done,
  output logic                oob
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SWEEP  = 2'd2
  } state_t;

  localparam logic [IN_SIZE-1:0]  OUT_MAX  = IN_SIZE'(OUT_SIZE);
  localparam logic [OUT_SIZE-1:0] ONE_HOT0 = OUT_SIZE'(1);

  state_t              state_q, state_d;
  logic [OUT_SIZE-1:0] out_q, out_d;
  logic [IN_SIZE-1:0]  cur_q, cur_d;
  logic [IN_SIZE-1:0]  end_q, end_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                oob_q, oob_d;
  logic                done_q, done_d;
  logic                in_range;

  assign in_range = (in != '0) && (in <= OUT_MAX);
  assign in_ready = (state_q != SWEEP);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cur_d   = cur_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    oob_d   = oob_q;
    done_d  = 1'b0;

    // Abort wins over any request arriving in the same cycle.
    if (clr) begin
      state_d = IDLE;
      out_d   = '0;
      oob_d   = 1'b0;
      cur_d   = '0;
      end_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DIRECT: begin
          if (in_valid) begin
            oob_d = !in_range;
            if (mode) begin
              if (in_range) begin
                cur_d   = IN_SIZE'(1);
                end_d   = in;
                cnt_d   = dwell;
                dwell_d = dwell;
                out_d   = ONE_HOT0;
                state_d = SWEEP;
              end else begin
                out_d   = '0;
                state_d = IDLE;
              end
            end else begin
              out_d   = in_range ? (ONE_HOT0 << (in - IN_SIZE'(1))) : '0;
              state_d = DIRECT;
            end
          end
        end
        SWEEP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (cur_q != end_q) begin
            cur_d = cur_q + IN_SIZE'(1);
            out_d = out_q << 1;
            cnt_d = dwell_q;
          end else begin
            out_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      cur_q   <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      oob_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      oob_q   <= oob_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == SWEEP);
  assign done = done_q;
  assign oob  = oob_q;

endmodule

// File: doc/decoder_seq_out.md
DECODER_SEQ_OUT -- requirements
Module: decoder_seq_out

Interface
REQ-001: Parameter IN_SIZE, default 6, width of index input.
REQ-002: Parameter OUT_SIZE, default 34, number of one-hot outputs; SHALL satisfy OUT_SIZE < 2**IN_SIZE.
REQ-003: Parameter DWELL_W, default 8, width of dwell count.
REQ-004: clk  in  1  single clock; all state updates on rising edge.
REQ-005: rst  in  1  reset, synchronous, active-high.
REQ-006: in  in  IN_SIZE  index; value k in 1..OUT_SIZE selects out[k-1]; direct target or sweep end index.
REQ-007: mode  in  1  0 = DIRECT, 1 = SWEEP; sampled only on accept.
REQ-008: in_valid  in  1  request strobe.
REQ-009: dwell  in  DWELL_W  per-output hold count for sweep; sampled only on accept.
REQ-010: clr  in  1  synchronous abort/clear.
REQ-011: in_ready  out  1  request can be accepted this cycle.
REQ-012: out  out  OUT_SIZE  registered one-hot (or all-zero) select.
REQ-013: busy  out  1  high while in SWEEP state.
REQ-014: done  out  1  one-cycle pulse at normal sweep completion.
REQ-015: oob  out  1  last accepted index was 0 or > OUT_SIZE.

Function
REQ-016: FSM states SHALL be IDLE, DIRECT, SWEEP; accept = in_valid & in_ready.
REQ-017: in_ready SHALL be 1 in IDLE and DIRECT, 0 in SWEEP (combinational from state).
REQ-018: All outputs except in_ready SHALL be registered; out updates on the edge that accepts a request (1-cycle latency).
REQ-019: Decode: valid k -> out = 1 << (k-1); k = 0 or k > OUT_SIZE -> out = 0.
REQ-020: Every accept SHALL update oob = (in == 0) | (in > OUT_SIZE); oob holds until next accept, clr or reset.
REQ-021: Accept with mode=0 (from IDLE or DIRECT): out <= decode(in), state -> DIRECT; out then held until next accept, clr or reset.
REQ-022: Accept with mode=1 and valid end index E: cur <= 1, end <= E, cnt <= dwell, out <= 1 (bit 0), state -> SWEEP.
REQ-023: Accept with mode=1 and out-of-range index: out <= 0, oob <= 1, state -> IDLE, no done pulse.
REQ-024: SWEEP: each cycle with cnt != 0, cnt decrements, out held; each selected output is held exactly dwell+1 cycles.
REQ-025: SWEEP with cnt == 0 and cur < end: cur <= cur+1, out <= out << 1, cnt <= dwell.
REQ-026: SWEEP with cnt == 0 and cur == end: out <= 0, done <= 1 for one cycle, state -> IDLE.
REQ-027: Sweep to E with dwell D SHALL drive outputs for exactly E*(D+1) cycles; dwell=0 gives one cycle per output.
REQ-028: in_valid during SWEEP SHALL be ignored (no state, oob or dwell change).
REQ-029: clr SHALL have priority over accept: next edge out <= 0, oob <= 0, done <= 0, state -> IDLE; no done pulse for an aborted sweep.
REQ-030: A sweep to E = OUT_SIZE SHALL reach out[OUT_SIZE-1] and never wrap to bit 0.
REQ-031: done SHALL be 0 in every cycle except the one following completion per REQ-026.

Reset
REQ-032: rst SHALL have priority over clr and accept; on the edge with rst=1: state IDLE, out=0, oob=0, done=0, busy=0, cur/cnt/end=0.
REQ-033: rst asserted mid-sweep SHALL terminate it with no done pulse; in_ready=1 in the first cycle after reset.

Verification (defaults IN_SIZE=6, OUT_SIZE=34)
REQ-034: DIRECT sweep of in=1..34, one accept per cycle -> out = 1<<(in-1) one cycle after each accept, oob=0, done never 1.
REQ-035: DIRECT in=0 then in=40 -> out=0 and oob=1 after each; next in=5 -> out=34'h10, oob=0.
REQ-036: SWEEP in=3, dwell=1 -> out=1 for 2 cycles, 2 for 2, 4 for 2, then out=0 with done=1 for one cycle, busy=1 throughout the 6 cycles, in_ready=0 throughout.
REQ-037: SWEEP in=34, dwell=0 -> 34 consecutive cycles walking bit 0..33, then out=0, done=1; in_valid pulses mid-sweep ignored.
REQ-038: SWEEP in=10, dwell=3, clr asserted while out=4 -> next cycle out=0, busy=0, done stays 0; rst at same point gives identical outputs.
REQ-039: SWEEP in=35 -> out stays 0, oob=1, busy never 1, done never 1, in_ready stays 1.
